// File: rtl/dct_block_serializer.sv
// dct_block_serializer
// Ping-pong buffer behind the 8x8 DCT core. It takes one whole 64-coefficient
// block per valid/ready handshake and streams it out one word per cycle.
// Build option: define DCT_SER_ZIGZAG_EN to emit words in JPEG zig-zag order.
// Without it, words are emitted in raster order.
// out_index always reports the raster position of the word being emitted.

module dct_block_serializer #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W*WORDS-1:0]   in_block,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [5:0]                out_index,
    output logic                      out_last,
    input  logic                      out_ready
);

    // Occupancy of the two slots doubles as the control state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t              state_reg;
    occ_t              state_next;
    logic              wp_reg;
    logic              rp_reg;
    logic [5:0]        k_reg;
    logic [5:0]        order_idx;
    logic              accept;
    logic              pop;
    logic              final_pop;

    logic [DATA_W-1:0] in_words [WORDS];
    logic [DATA_W-1:0] slot_mem [2][WORDS];

    // Split the flat input bus into per-word lanes.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_unpack
            assign in_words[gi] = in_block[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef DCT_SER_ZIGZAG_EN
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    assign order_idx = ZIGZAG[k_reg];
`else
    assign order_idx = k_reg;
`endif

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign final_pop = pop & (k_reg == 6'd63);

    // State, pointers and emission counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            wp_reg    <= 1'b0;
            rp_reg    <= 1'b0;
            k_reg     <= 6'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                wp_reg <= ~wp_reg;
            end
            if (pop) begin
                // k wraps from 63 to 0 on its own; the final pop also releases the slot.
                k_reg <= k_reg + 6'd1;
            end
            if (final_pop) begin
                rp_reg <= ~rp_reg;
            end
        end
    end

    // Occupancy transitions. An accept together with a final pop leaves occupancy unchanged.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && !final_pop) begin
                    state_next = FULL;
                end else if (final_pop && !accept) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (final_pop) begin
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake and stream outputs. They depend only on registered state, plus rst for in_ready.
    always_comb begin
        in_ready  = !rst && (state_reg != FULL);
        out_valid = (state_reg != EMPTY);
        out_index = order_idx;
        out_last  = out_valid && (k_reg == 6'd63);
        // Slot contents are not cleared on reset. Gate them so idle output reads as zero.
        out_data  = out_valid ? slot_mem[rp_reg][order_idx] : '0;
    end

    // Capture an entire block into the free slot on the accepting edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < WORDS; i++) begin
                slot_mem[wp_reg][i] <= in_words[i];
            end
        end
    end

endmodule

// File: tb/tb_dct_block_serializer.sv
// Directed testbench for dct_block_serializer.
// Block b carries word i = b*256 + i. A small occupancy/queue model supplies
// the expected outputs for each cycle. Hand-computed checkpoints pin down the
// handshake timing.

module tb_dct_block_serializer;

    localparam int DATA_W = 32;
    localparam int WORDS  = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic [DATA_W*WORDS-1:0]  in_block;
    logic                     in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [5:0]               out_index;
    logic                     out_last;
    logic                     out_ready;

    dct_block_serializer #(.DATA_W(DATA_W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_block  (in_block),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state.
    int m_occ = 0;
    int m_k   = 0;
    int q[$];
    int words_popped = 0;

`ifdef DCT_SER_ZIGZAG_EN
    int zz [64] = '{
        0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    function automatic int ord(input int k);
        return zz[k];
    endfunction
`else
    function automatic int ord(input int k);
        return k;
    endfunction
`endif

    function automatic logic [DATA_W*WORDS-1:0] make_block(input int b);
        logic [DATA_W*WORDS-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            v[i*DATA_W +: DATA_W] = 32'(b * 256 + i);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model, advance.
    task automatic cycle(input logic iv, input int blk, input logic ordy, output logic accepted);
        logic exp_v;
        logic exp_r;
        in_valid  = iv;
        in_block  = make_block(blk);
        out_ready = ordy;
        exp_v = (m_occ != 0);
        exp_r = (m_occ != 2);
        chk("in_ready", 64'(in_ready), 64'(exp_r));
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            chk("out_data", 64'(out_data), 64'(q[0] * 256 + ord(m_k)));
            chk("out_index", 64'(out_index), 64'(ord(m_k)));
            chk("out_last", 64'(out_last), 64'(m_k == 63));
        end else begin
            chk("idle_last", 64'(out_last), 64'(0));
        end
        @(posedge clk);
        accepted = iv && exp_r;
        if (accepted) begin
            q.push_back(blk);
            m_occ++;
            $display("accept block %0d at %0t", blk, $time);
        end
        if (exp_v && ordy) begin
            words_popped++;
            if (m_k == 63) begin
                $display("block %0d emitted at %0t", q[0], $time);
                m_k = 0;
                void'(q.pop_front());
                m_occ--;
            end else begin
                m_k++;
            end
        end
        #1;
    endtask

    task automatic model_clear();
        m_occ = 0;
        m_k   = 0;
        q.delete();
    endtask

    initial begin
        logic acc;
        int   nb;
        int   rc;
        int   guard;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_index", 64'(out_index), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        rst = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'(1));
        model_clear();

        // Single block, continuous out_ready.
        words_popped = 0;
        cycle(1'b1, 0, 1'b1, acc);
        chk("t1_accept", 64'(acc), 64'(1));
        chk("t1_latency_valid", 64'(out_valid), 64'(1));
        for (int c = 0; c < 70; c++) begin
            cycle(1'b0, 0, 1'b1, acc);
        end
        chk("t1_words", 64'(words_popped), 64'(64));

        // Four blocks back-to-back with in_valid held whenever a block is pending.
        words_popped = 0;
        nb = 0;
        rc = 0;
        guard = 0;
        while (!(nb == 4 && m_occ == 0) && guard < 400) begin
            if (rc == 2) begin
                chk("t2_full_in_ready", 64'(in_ready), 64'(0));
            end
            if (rc == 64) begin
                chk("t2_lastpop_in_ready", 64'(in_ready), 64'(0));
                chk("t2_lastpop_last", 64'(out_last), 64'(1));
            end
            if (rc == 65) begin
                chk("t2_freed_in_ready", 64'(in_ready), 64'(1));
                chk("t2_next_block_word0", 64'(out_data), 64'(256 + ord(0)));
            end
            cycle(nb < 4, nb, 1'b1, acc);
            if (acc) nb++;
            rc++;
            guard++;
        end
        chk("t2_words", 64'(words_popped), 64'(256));
        chk("t2_cycles", 64'(rc), 64'(257));

        // Random back-pressure, about 80% out_ready.
        words_popped = 0;
        nb = 0;
        guard = 0;
        while (!(nb == 3 && m_occ == 0) && guard < 2000) begin
            cycle(nb < 3, 8 + nb, ($urandom_range(0, 9) < 8), acc);
            if (acc) nb++;
            guard++;
        end
        chk("t3_words", 64'(words_popped), 64'(192));
        chk("t3_drained", 64'(m_occ), 64'(0));

        // Reset mid-stream with one block buffered behind the active one.
        cycle(1'b1, 20, 1'b1, acc);
        cycle(1'b1, 21, 1'b1, acc);
        guard = 0;
        while (m_k != 20 && guard < 100) begin
            cycle(1'b0, 0, 1'b1, acc);
            guard++;
        end
        chk("t4_at_word20", 64'(out_index), 64'(ord(20)));
        rst      = 1'b1;
        in_valid = 1'b1;
        in_block = make_block(22);
        #1;
        chk("t4_rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("t4_rst_out_valid", 64'(out_valid), 64'(0));
        chk("t4_rst_out_last", 64'(out_last), 64'(0));
        chk("t4_rst_out_index", 64'(out_index), 64'(0));
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t4_release_in_ready", 64'(in_ready), 64'(1));
        chk("t4_release_out_valid", 64'(out_valid), 64'(0));
        model_clear();
        words_popped = 0;
        cycle(1'b1, 30, 1'b1, acc);
        chk("t4_fresh_index0", 64'(out_index), 64'(0));
        chk("t4_fresh_data0", 64'(out_data), 64'(30 * 256));
        guard = 0;
        while (m_occ != 0 && guard < 200) begin
            cycle(1'b0, 0, 1'b1, acc);
            guard++;
        end
        chk("t4_words", 64'(words_popped), 64'(64));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_block_serializer.md
# dct_block_serializer

Output-side companion of the pipelined 8×8 2-D DCT core.
- Accepts one full 64-coefficient block per valid/ready handshake, exactly as the DCT core presents it on its output port.
- Streams the coefficients out one word per cycle toward the quantizer/entropy stage.
- Holds two blocks (ping-pong), so the DCT core can hand over its next block while the current one is still streaming.

## Interface
Parameters:
- DATA_W, 32, coefficient width (signed fixed point, 8 fractional bits; passed through unmodified)
- WORDS, 64, words per block; fixed at 64 (8×8), other values unsupported

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  block available from DCT core
- in_block  input  DATA_W*WORDS  block; word i = row*8+col at bits [i*DATA_W +: DATA_W]
- in_ready  output  1  a buffer slot is free
- out_valid  output  1  out_data holds a valid coefficient
- out_data  output  DATA_W  current coefficient
- out_index  output  6  raster index (row*8+col) of out_data
- out_last  output  1  out_data is the final word of its block
- out_ready  input  1  downstream accepts out_data

## Operation
- Storage: two block slots, write pointer wp, read pointer rp, occupancy occ ∈ {0,1,2}, emission counter k (6 bits).
- Accept: on in_valid & in_ready, in_block is copied into slot[wp], wp toggles, and occ increments.
- in_ready = !rst & (occ != 2). It has no combinational dependence on out_ready or in_valid.
- Emit: out_valid = (occ != 0). out_data = slot[rp] word ORDER(k). out_index = ORDER(k). out_last = (k == 63).
- Pop: on out_valid & out_ready, k increments. When k == 63, k wraps to 0, rp toggles, and occ decrements.
- Simultaneous accept and final pop in the same cycle: occ is unchanged, both pointers move, and no data is lost.
- When occ == 2, in_ready is 0 for that cycle even if the final word is popping; the freed slot is offered on the next cycle.
- out_data, out_index and out_last must hold stable while out_valid & !out_ready.
- States (implicit in occ): EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without final pop.
  - ONE→EMPTY on final pop without accept.
  - FULL→ONE on final pop.
- Reset mid-stream: any partially emitted block and any buffered block are discarded. k, rp, wp and occ are cleared, and the next accepted block starts at k=0.

## Timing
- Reset values: out_valid=0, out_last=0, out_index=0, out_data=0. in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Latency: a block accepted at edge N presents word ORDER(0) with out_valid=1 after edge N (visible in cycle N+1) when occ was 0.
- Throughput: with out_ready held high, one word per cycle and exactly 64 cycles per block. There are no bubbles between consecutive buffered blocks; out_last of block b is followed directly by word 0 of block b+1.
- A block enters only through a handshake; in_block is sampled only on the accepting edge.

## Configuration
- DCT_SER_ZIGZAG_EN:
  - Defined: ORDER(k) is the JPEG zig-zag sequence 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63. It is implemented as a 64-entry constant lookup.
  - Undefined: ORDER(k)=k (raster order).
  - In both cases out_index reports the raster index of the emitted word.

## Test plan
- Single block, word i = i, out_ready=1, macro undefined → out_valid rises the cycle after accept, out_data/out_index = 0..63 on 64 consecutive cycles, out_last only on 63, in_ready stays 1.
- Same block with DCT_SER_ZIGZAG_EN defined → out_index sequence 0,1,8,16,9,2,… ending 62,63; out_data equals out_index each cycle.
- Four blocks sent back-to-back (block b word i = b*256+i), out_ready=1 → 256 words with no gap; in_ready drops to 0 after the second accept and returns 1 the cycle after the first block's out_last pop.
- Random back-pressure, 80% out_ready high → output is stable whenever stalled, and the sequence is identical to the no-stall case; no word is duplicated or dropped.
- FULL with final pop and new in_valid in the same cycle → no accept that cycle (in_ready=0); accept occurs on the next cycle; order of blocks is preserved.
- Assert rst at word 20 of block 0 with block 1 buffered → next cycle out_valid=0 and in_ready=1 after release; a fresh block then streams from index 0.
